pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/common_def.sv | 13 +
 rtl/load_use_detect.sv | 17 +
 rtl/pipe_ctrl_unit.sv | 162 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_def.sv
// Shared definitions for the pipeline hazard/sequencing controller.
package common_def;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALT     = 2'd3
    } ctrl_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect between ID/EX load and IF/ID sources.
module load_use_detect (
    input  logic       idex_memRead,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_use_rs1,
    input  logic       ifid_use_rs2,
    output logic       load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign load_use = idex_memRead && (idex_rd != 5'd0) &&
                      ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush controller: load-use, mispredict, memory wait, ECALL drain/halt.
//   state    | meaning
//   RUN      | normal issue; load-use / mispredict / ECALL entry handled
//   MEM_WAIT | data memory busy; whole pipe frozen, timeout down-counter running
//   DRAIN    | ECALL in flight; front end flushed until it reaches MEM/WB
//   HALT     | pipe frozen; leaves on resume unless a memory timeout occurred
module pipe_ctrl_unit
    import common_def::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        idex_memRead,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_use_rs1,
    input  logic        ifid_use_rs2,
    input  logic        mispredict_ex,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        ecall_exmem,
    input  logic        ecall_memwb,
    input  logic        resume,
    output logic        stall_ifid,
    output logic        stall_idex,
    output logic        stall_exmem,
    output logic        stall_memwb,
    output logic        pc_hold,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        halted,
    output logic        mem_err,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mem_err_q, mem_err_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;
    logic [31:0]       mis_cnt_q, mis_cnt_d;

    logic load_use;
    logic mem_stall;
    logic hold_all, pc_hold_c, stall_ifid_c;
    logic flush_ifid_c, flush_idex_c, flush_exmem_c;
    logic mis_applied;

    load_use_detect u_lud (
        .idex_memRead (idex_memRead),
        .idex_rd      (idex_rd),
        .ifid_rs1     (ifid_rs1),
        .ifid_rs2     (ifid_rs2),
        .ifid_use_rs1 (ifid_use_rs1),
        .ifid_use_rs2 (ifid_use_rs2),
        .load_use     (load_use)
    );

    assign mem_stall = dmem_req && !dmem_ready;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_err_d     = mem_err_q;
        hold_all      = 1'b0;
        pc_hold_c     = 1'b0;
        stall_ifid_c  = 1'b0;
        flush_ifid_c  = 1'b0;
        flush_idex_c  = 1'b0;
        flush_exmem_c = 1'b0;
        mis_applied   = 1'b0;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    hold_all = 1'b1;
                    if (state_q == RUN) begin
                        state_d = MEM_WAIT;
                        wait_d  = WAIT_LOAD;
                    end else if (wait_q == '0) begin
                        state_d   = HALT;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end else begin
                    state_d = RUN;
                    // the older ECALL wins over a younger mispredict or load-use
                    if (ecall_exmem) begin
                        state_d      = DRAIN;
                        pc_hold_c    = 1'b1;
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                    end else if (mispredict_ex) begin
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                        mis_applied  = 1'b1;
                    end else if (load_use) begin
                        pc_hold_c    = 1'b1;
                        stall_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                pc_hold_c    = 1'b1;
                flush_ifid_c = 1'b1;
                flush_idex_c = 1'b1;
                if (ecall_memwb) begin
                    flush_exmem_c = 1'b1;
                    state_d       = HALT;
                end
            end
            HALT: begin
                hold_all = 1'b1;
                if (resume && !mem_err_q) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_cnt_d = stall_cnt_q + (((pc_hold_c || hold_all) && (state_q != HALT)) ? 32'd1 : 32'd0);
    assign mis_cnt_d   = mis_cnt_q + (mis_applied ? 32'd1 : 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            mis_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            mis_cnt_q   <= mis_cnt_d;
        end
    end

    // control outputs are forced quiet while reset is held, whatever the inputs do
    assign stall_ifid     = rst_n && (hold_all || stall_ifid_c);
    assign stall_idex     = rst_n && hold_all;
    assign stall_exmem    = rst_n && hold_all;
    assign stall_memwb    = rst_n && hold_all;
    assign pc_hold        = rst_n && (hold_all || pc_hold_c);
    assign flush_ifid     = rst_n && flush_ifid_c;
    assign flush_idex     = rst_n && flush_idex_c;
    assign flush_exmem    = rst_n && flush_exmem_c;
    assign halted         = (state_q == HALT);
    assign mem_err        = mem_err_q;
    assign state          = state_q;
    assign stall_cnt      = stall_cnt_q;
    assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus randomized run against a rule model.
module tb_pipe_ctrl_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idex_memRead;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        ifid_use_rs1, ifid_use_rs2, mispredict_ex;
    logic        dmem_req, dmem_ready, ecall_exmem, ecall_memwb, resume;
    logic        stall_ifid, stall_idex, stall_exmem, stall_memwb, pc_hold;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic        halted, mem_err;
    logic [1:0]  state;
    logic [31:0] stall_cnt, mispredict_cnt;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    // behavioural model state: mode 0..3, upward wait count, sticky error, counters
    int          m_mode;
    int          m_wait;
    bit          m_err;
    logic [31:0] m_stall;
    logic [31:0] m_mis;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_memRead(idex_memRead), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .mispredict_ex(mispredict_ex),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .ecall_exmem(ecall_exmem), .ecall_memwb(ecall_memwb), .resume(resume),
        .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .stall_memwb(stall_memwb), .pc_hold(pc_hold),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .halted(halted), .mem_err(mem_err), .state(state),
        .stall_cnt(stall_cnt), .mispredict_cnt(mispredict_cnt)
    );

    assign ctl = {stall_ifid, stall_idex, stall_exmem, stall_memwb,
                  pc_hold, flush_ifid, flush_idex, flush_exmem};

    task automatic idle_inputs();
        idex_memRead = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        ifid_use_rs1 = 0; ifid_use_rs2 = 0; mispredict_ex = 0;
        dmem_req = 0; dmem_ready = 0; ecall_exmem = 0; ecall_memwb = 0; resume = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0; m_mis = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        idle_inputs();
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // expected {stall_ifid,stall_idex,stall_exmem,stall_memwb,pc_hold,flush_ifid,flush_idex,flush_exmem}
    function automatic logic [7:0] model_ctl(int mode);
        bit lu;
        lu = idex_memRead && (idex_rd != 0) &&
             ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
        if (mode == 3) return 8'b1111_1000;
        if (mode == 2) return {7'b0000_111, ecall_memwb};
        if (dmem_req && !dmem_ready) return 8'b1111_1000;
        if (ecall_exmem)   return 8'b0000_1110;
        if (mispredict_ex) return 8'b0000_0110;
        if (lu)            return 8'b1000_1010;
        return 8'b0;
    endfunction

    task automatic model_clock();
        logic [7:0] e;
        e = model_ctl(m_mode);
        if (e[3] && m_mode != 3) m_stall = m_stall + 1;
        case (m_mode)
            3: if (resume && !m_err) m_mode = 0;
            2: if (ecall_memwb) m_mode = 3;
            default: begin
                if (dmem_req && !dmem_ready) begin
                    if (m_mode == 0) begin
                        m_mode = 1;
                        m_wait = 0;
                    end else begin
                        m_wait = m_wait + 1;
                        if (m_wait == TO) begin
                            m_mode = 3;
                            m_err  = 1;
                        end
                    end
                end else if (ecall_exmem) begin
                    m_mode = 2;
                end else begin
                    m_mode = 0;
                    if (mispredict_ex) m_mis = m_mis + 1;
                end
            end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        idex_memRead = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
        dmem_req = 1; dmem_ready = 0; mispredict_ex = 1;
        #2;
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl got %b want 00000000", ctl); end
        checks++;
        if (state !== 2'd0 || halted !== 1'b0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_state got state=%0d halted=%b mem_err=%b want 0 0 0", state, halted, mem_err);
        end
        checks++;
        if (stall_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, mispredict_cnt);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        tick();
        idex_memRead = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
        #1;
        checks++;
        if (ctl !== 8'b1000_1010) begin errors++; $display("FAIL load_use_ctl got %b want 10001010", ctl); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL load_use_release got %b want 00000000", ctl); end
        checks++;
        if (stall_cnt !== 32'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
    endtask

    task automatic test_rd_x0();
        tick();
        idex_memRead = 1; idex_rd = 0; ifid_rs2 = 0; ifid_use_rs2 = 1;
        #1;
        checks++;
        if (ctl !== 8'h00) begin errors++; $display("FAIL rd_x0_ctl got %b want 00000000", ctl); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 32'd1) begin errors++; $display("FAIL rd_x0_cnt got %0d want 1", stall_cnt); end
    endtask

    task automatic test_mispredict_lu();
        tick();
        idex_memRead = 1; idex_rd = 7; ifid_rs1 = 7; ifid_use_rs1 = 1; mispredict_ex = 1;
        #1;
        checks++;
        if (flush_ifid !== 1'b1 || flush_idex !== 1'b1 || stall_ifid !== 1'b0) begin
            errors++; $display("FAIL mis_lu_ctl got fi=%b fd=%b si=%b want 1 1 0", flush_ifid, flush_idex, stall_ifid);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (mispredict_cnt !== 32'd1) begin errors++; $display("FAIL mis_lu_cnt got %0d want 1", mispredict_cnt); end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            tick();
            dmem_req = 1; dmem_ready = 0;
            #1;
            checks++;
            if (ctl !== 8'b1111_1000 || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++; $display("FAIL mem_wait_%0d got ctl=%b state=%0d", i, ctl, state);
            end
        end
        tick();
        dmem_ready = 1;
        #1;
        checks++;
        if (ctl !== 8'h00 || state !== 2'd1) begin
            errors++; $display("FAIL mem_ready got ctl=%b state=%0d want 00000000 1", ctl, state);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (state !== 2'd0 || stall_cnt !== 32'd4) begin
            errors++; $display("FAIL mem_after got state=%0d cnt=%0d want 0 4", state, stall_cnt);
        end
    endtask

    task automatic test_ecall();
        tick();
        ecall_exmem = 1;
        #1;
        checks++;
        if (ctl !== 8'b0000_1110) begin errors++; $display("FAIL ecall_entry got %b want 00001110", ctl); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (state !== 2'd2 || ctl !== 8'b0000_1110) begin
            errors++; $display("FAIL ecall_drain got state=%0d ctl=%b", state, ctl);
        end
        tick();
        ecall_memwb = 1;
        #1;
        checks++;
        if (ctl !== 8'b0000_1111) begin errors++; $display("FAIL ecall_memwb got %b want 00001111", ctl); end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (state !== 2'd3 || halted !== 1'b1 || ctl !== 8'b1111_1000) begin
            errors++; $display("FAIL ecall_halt got state=%0d halted=%b ctl=%b", state, halted, ctl);
        end
        tick();
        resume = 1;
        #1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (state !== 2'd0 || halted !== 1'b0) begin
            errors++; $display("FAIL ecall_resume got state=%0d halted=%b want 0 0", state, halted);
        end
        checks++;
        if (stall_cnt !== 32'd7) begin errors++; $display("FAIL ecall_cnt got %0d want 7", stall_cnt); end
    endtask

    task automatic test_random();
        logic [7:0] e;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            tick();
            if (m_err || $urandom_range(0, 199) == 0) begin
                do_reset();
                tick();
            end
            idex_memRead  = 1'($urandom_range(0, 1));
            idex_rd       = 5'($urandom_range(0, 3));
            ifid_rs1      = 5'($urandom_range(0, 3));
            ifid_rs2      = 5'($urandom_range(0, 3));
            ifid_use_rs1  = 1'($urandom_range(0, 1));
            ifid_use_rs2  = 1'($urandom_range(0, 1));
            mispredict_ex = ($urandom_range(0, 3) == 0);
            dmem_req      = ($urandom_range(0, 2) == 0);
            dmem_ready    = ($urandom_range(0, 3) != 0);
            ecall_exmem   = ($urandom_range(0, 9) == 0);
            ecall_memwb   = ($urandom_range(0, 3) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            #1;
            e = model_ctl(m_mode);
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL rnd_ctl n=%0d got %b want %b", n, ctl, e); end
            checks++;
            if (state !== 2'(m_mode) || halted !== (m_mode == 3) || mem_err !== m_err) begin
                errors++; $display("FAIL rnd_state n=%0d got %0d/%b/%b want %0d/%b/%b",
                                   n, state, halted, mem_err, m_mode, (m_mode == 3), m_err);
            end
            checks++;
            if (stall_cnt !== m_stall || mispredict_cnt !== m_mis) begin
                errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d",
                                   n, stall_cnt, mispredict_cnt, m_stall, m_mis);
            end
            model_clock();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k <= TO; k++) begin
            tick();
            dmem_req = 1; dmem_ready = 0;
            #1;
            checks++;
            if (state !== ((k == 0) ? 2'd0 : 2'd1) || mem_err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait_%0d got state=%0d mem_err=%b", k, state, mem_err);
            end
        end
        tick();
        #1;
        checks++;
        if (state !== 2'd3 || mem_err !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL timeout_halt got state=%0d mem_err=%b halted=%b want 3 1 1", state, mem_err, halted);
        end
        idle_inputs();
        resume = 1;
        repeat (2) tick();
        checks++;
        if (state !== 2'd3 || mem_err !== 1'b1) begin
            errors++; $display("FAIL timeout_resume got state=%0d mem_err=%b want 3 1", state, mem_err);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || mem_err !== 1'b0 || halted !== 1'b0 || ctl !== 8'h00) begin
            errors++; $display("FAIL reset_mid got state=%0d mem_err=%b halted=%b ctl=%b", state, mem_err, halted, ctl);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_x0();
        test_mispredict_lu();
        test_mem_wait();
        test_ecall();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
